// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ
// requesters. An accepted op is captured, driven to the ALU for one cycle,
// and its result is held as a response until the consumer takes it.
module alu_share_arbiter #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 64,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][2:0]        req_cntrl,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
    input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
    output logic [NREQ-1:0]             req_ready,
    output logic [2:0]                  alu_cntrl,
    output logic [WIDTH-1:0]            alu_a,
    output logic [WIDTH-1:0]            alu_b,
    input  logic [WIDTH-1:0]            alu_result,
    input  logic [3:0]                  alu_flags,
    output logic                        rsp_valid,
    output logic [IDW-1:0]              rsp_id,
    output logic [WIDTH-1:0]            rsp_result,
    output logic [3:0]                  rsp_flags,
    input  logic                        rsp_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [2:0]       op_cntrl_q, op_cntrl_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    int unsigned      scan_pos;
    logic [IDW-1:0]   scan_idx;

    // Pick the first valid requester scanning upward from rr_ptr with wrap at NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_pos    = 0;
        scan_idx    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_pos = 32'(rr_ptr_q) + off;
            if (scan_pos >= NREQ) begin
                scan_pos = scan_pos - NREQ;
            end
            scan_idx = IDW'(scan_pos);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // One-hot accept, only while idle and never while reset is asserted
    always_comb begin
        req_ready = '0;
        if (reset && (state_q == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state, operand capture and response capture
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_cntrl_d   = op_cntrl_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_cntrl_d = req_cntrl[grant_idx];
                    op_a_d     = req_a[grant_idx];
                    op_b_d     = req_b[grant_idx];
                    id_d       = grant_idx;
                    rr_ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_cntrl_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_cntrl_q   <= op_cntrl_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_cntrl  = op_cntrl_q;
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule
